// File: rtl/imem_loader_pkg.sv
// Shared constants and loader state encoding for the IMEM boot/debug loader.
package imem_loader_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned IMEM_DEPTH = 1024;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } ld_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream link into the loader plus the IMEM write port it drives.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            rx_ready;
    logic            imem_we;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Collects four stream bytes LSB-first into a 32-bit word; flags the 4th byte combinationally.
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [7:0]      din,
    output logic            word_valid_c,
    output logic [XLEN-1:0] word_c
);

    logic [1:0]  lane;
    logic [23:0] part;

    // Lane counter wraps 3->0; byte 3 is never stored, it completes the word directly.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            lane <= '0;
            part <= '0;
        end else if (en) begin
            unique case (lane)
                2'd0:    part[7:0]   <= din;
                2'd1:    part[15:8]  <= din;
                2'd2:    part[23:16] <= din;
                default: ;
            endcase
            lane <= lane + 2'd1;
        end
    end

    always_comb begin
        word_valid_c = en && (lane == 2'd3);
        word_c       = {din, part};
    end

endmodule

// File: rtl/imem_loader.sv
// IMEM writer: parses a length-prefixed byte stream and issues one IMEM write per word.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

    ld_state_e         state;
    ld_state_e         state_nxt;
    logic [7:0]        cnt_lo;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  hdr_c;
    logic [IDX_W-1:0]  word_idx;
    logic              xfer_c;
    logic              start_take_c;
    logic              data_en_c;
    logic              word_valid_c;
    logic              last_word_c;
    logic [XLEN-1:0]   word_c;
    logic              rx_ready_q;
    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              rdy_nxt;
    logic              busy_nxt;
    logic              hold_nxt;
    logic              done_nxt;
    logic              err_nxt;

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    always_comb begin
        xfer_c       = bus.rx_valid & rx_ready_q;
        start_take_c = start && ((state == IDLE) || (state == DONE) || (state == ERR));
        data_en_c    = xfer_c && (state == DATA);
        hdr_c        = CNT_W'({bus.rx_data, cnt_lo});
        last_word_c  = word_valid_c && ((CNT_W'(word_idx) + CNT_W'(1)) == cnt);
    end

    imem_loader_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (start_take_c),
        .en           (data_en_c),
        .din          (bus.rx_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN0;
            LEN0:            if (xfer_c) state_nxt = LEN1;
            LEN1: begin
                if (xfer_c) begin
                    if (hdr_c == '0)                  state_nxt = DONE;
                    else if (32'(hdr_c) > 32'(DEPTH)) state_nxt = ERR;
                    else                              state_nxt = DATA;
                end
            end
            DATA:            if (last_word_c) state_nxt = DONE;
            default:         state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from next-state so rx_ready never depends on rx_valid.
    always_comb begin
        busy_nxt = (state_nxt == LEN0) || (state_nxt == LEN1) || (state_nxt == DATA);
        rdy_nxt  = busy_nxt;
        hold_nxt = busy_nxt | last_word_c;
        done_nxt = done;
        err_nxt  = err;
        if (start_take_c) begin
            done_nxt = 1'b0;
            err_nxt  = 1'b0;
        end
        if ((state != DONE) && (state_nxt == DONE)) done_nxt = 1'b1;
        if ((state != ERR) && (state_nxt == ERR))   err_nxt  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ready_q <= 1'b0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_idx   <= '0;
            cnt_lo     <= '0;
            cnt        <= '0;
        end else begin
            rx_ready_q <= rdy_nxt;
            busy       <= busy_nxt;
            cpu_hold   <= hold_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            we_q       <= word_valid_c;
            if (word_valid_c) begin
                addr_q   <= XLEN'({word_idx, 2'b00});
                wdata_q  <= word_c;
                word_idx <= word_idx + IDX_W'(1);
            end
            if (xfer_c && (state == LEN0)) cnt_lo <= bus.rx_data;
            if (xfer_c && (state == LEN1)) cnt    <= hdr_c;
            if (start_take_c)              word_idx <= '0;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader against a stream-level write model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, busy, done, err;

    imem_loader_if bus();

    imem_loader #(.DEPTH(1024), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] wq[$];
    logic [63:0] expw[$];
    logic [7:0]  stim[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Capture every IMEM write; the core must be held in reset for each one.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wq.push_back({bus.imem_addr, bus.imem_wdata});
            chk("hold_during_write", 32'(cpu_hold), 32'd1);
        end
    end

    // Expected writes derived from the stream: header count, then little-endian words.
    task automatic model_from_stim();
        int cnt;
        expw.delete();
        cnt = int'(stim[0]) + 256 * int'(stim[1]);
        if (cnt == 0 || cnt > 1024) return;
        for (int i = 0; i < cnt; i++) begin
            if (2 + 4 * i + 3 < stim.size())
                expw.push_back({32'(i * 4), stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
        end
    endtask

    task automatic make_load(input int cnt);
        stim.delete();
        stim.push_back(8'(cnt));
        stim.push_back(8'(cnt >> 8));
        for (int i = 0; i < 4 * cnt; i++) stim.push_back(8'($urandom_range(0, 255)));
        model_from_stim();
    endtask

    task automatic do_start();
        wq.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(bus.rx_ready), 32'd1);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_err_clr", 32'(err), 32'd0);
    endtask

    // mode 0 full rate, 1 toggling valid, 2 random valid; start pulsed once at byte start_at.
    task automatic drive(input int mode, input int start_at);
        int idx = 0;
        int cyc = 0;
        bit v, acc, pulsed;
        pulsed = 1'b0;
        while (idx < stim.size() && cyc < 10000) begin
            if (mode == 1)      v = (cyc % 2 == 0);
            else if (mode == 2) v = ($urandom_range(0, 3) != 0);
            else                v = 1'b1;
            bus.rx_valid = v;
            bus.rx_data  = stim[idx];
            start = (start_at >= 0) && (idx == start_at) && !pulsed;
            if (start) pulsed = 1'b1;
            acc = v && (bus.rx_ready === 1'b1);
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        bus.rx_valid = 1'b0;
        start = 1'b0;
        chk("stream_consumed", 32'(idx), 32'(stim.size()));
    endtask

    task automatic end_check(input string tag);
        int n;
        n = expw.size();
        chk({tag, "_we_final"}, 32'(bus.imem_we), (n > 0) ? 32'd1 : 32'd0);
        chk({tag, "_hold_final"}, 32'(cpu_hold), (n > 0) ? 32'd1 : 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_hold_after"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_we_after"}, 32'(bus.imem_we), 32'd0);
        chk({tag, "_done_after"}, 32'(done), 32'd1);
        chk({tag, "_nwrites"}, 32'(wq.size()), 32'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            chk({tag, "_addr"}, wq[i][63:32], expw[i][63:32]);
            chk({tag, "_data"}, wq[i][31:0], expw[i][31:0]);
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
        chk({tag, "_we"}, 32'(bus.imem_we), 32'd0);
        chk({tag, "_addr"}, bus.imem_addr, 32'd0);
        chk({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_check("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of the second word
        make_load(4);
        while (stim.size() > 8) void'(stim.pop_back());
        model_from_stim();
        do_start();
        drive(0, -1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_check("midrst");
        rst_n = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5a;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_ready_idle", 32'(bus.rx_ready), 32'd0);
        end
        bus.rx_valid = 1'b0;
        chk("midrst_nwrites", 32'(wq.size()), 32'(expw.size()));
        if (wq.size() > 0) chk("midrst_word0", wq[0][31:0], expw[0][31:0]);

        // Two-word program
        stim = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03, 8'h60, 8'h00};
        model_from_stim();
        chk("model_w1", expw[1][31:0], 32'h00600313);
        do_start();
        drive(0, -1);
        end_check("two");

        // Zero count goes straight to DONE
        stim = '{8'h00, 8'h00};
        model_from_stim();
        do_start();
        drive(0, -1);
        end_check("zero");

        // Overflow header
        stim = '{8'h01, 8'h04};
        model_from_stim();
        do_start();
        drive(0, -1);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_ready", 32'(bus.rx_ready), 32'd0);
        chk("ovf_busy", 32'(busy), 32'd0);
        chk("ovf_hold", 32'(cpu_hold), 32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hee;
        repeat (3) begin
            @(negedge clk);
            chk("ovf_ready_hold", 32'(bus.rx_ready), 32'd0);
        end
        bus.rx_valid = 1'b0;
        chk("ovf_nwrites", 32'(wq.size()), 32'd0);

        // Throttled two-word program
        stim = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03, 8'h60, 8'h00};
        model_from_stim();
        do_start();
        drive(1, -1);
        end_check("thr");

        // Random loads with random valid gaps
        repeat (6) begin
            make_load(int'($urandom_range(1, 12)));
            do_start();
            drive(2, -1);
            end_check("rnd");
        end

        // Full-depth load at full rate, with a start pulse while busy
        make_load(1024);
        do_start();
        drive(0, 402);
        end_check("full");
        if (wq.size() > 0) chk("full_last_addr", wq[wq.size()-1][63:32], 32'h0000_0ffc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
